// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - operand issue and writeback stage around a combinational ALU
module alu_issue_stage #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [REG_AW-1:0] instr_rs,
  input  logic [REG_AW-1:0] instr_rt,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [WIDTH-1:0]  ld_data,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [2:0]        alu_op,
  input  logic [WIDTH-1:0]  alu_r0,
  input  logic              alu_overflow,
  input  logic              alu_zero,
  input  logic              alu_carry,
  output logic [WIDTH-1:0]  result,
  output logic              flag_v,
  output logic              flag_z,
  output logic              flag_c,
  output logic              done,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data
);

  localparam int NREG = 1 << REG_AW;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t            state;
  logic [WIDTH-1:0]  regs [NREG];
  logic [REG_AW-1:0] rd_q;
  logic              accept;

  assign instr_ready = (state == IDLE) && rst_n;
  assign accept      = instr_valid && instr_ready;

  // Entry 0 is never written, but the read is forced to zero so it cannot leak
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      rd_q   <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      result <= '0;
      flag_v <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Operand reads below sample pre-load contents through NBA semantics
          if (ld_en && (ld_addr != '0)) regs[ld_addr] <= ld_data;
          if (accept) begin
            alu_a  <= (instr_rs == '0) ? '0 : regs[instr_rs];
            alu_b  <= (instr_rt == '0) ? '0 : regs[instr_rt];
            alu_op <= instr_op;
            rd_q   <= instr_rd;
            state  <= EXEC;
          end
        end
        EXEC: begin
          result <= alu_r0;
          flag_v <= alu_overflow;
          flag_z <= alu_zero;
          flag_c <= alu_carry;
          done   <= 1'b1;
          state  <= WB;
        end
        WB: begin
          if (rd_q != '0) regs[rd_q] <= result;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

  localparam int WIDTH  = 32;
  localparam int REG_AW = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        instr_op;
  logic [REG_AW-1:0] instr_rs, instr_rt, instr_rd;
  logic              ld_en;
  logic [REG_AW-1:0] ld_addr;
  logic [WIDTH-1:0]  ld_data;
  logic [WIDTH-1:0]  alu_a, alu_b;
  logic [2:0]        alu_op;
  logic [WIDTH-1:0]  alu_r0;
  logic              alu_overflow, alu_zero, alu_carry;
  logic [WIDTH-1:0]  result;
  logic              flag_v, flag_z, flag_c;
  logic              done;
  logic [REG_AW-1:0] dbg_addr;
  logic [WIDTH-1:0]  dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.WIDTH(WIDTH), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rs(instr_rs), .instr_rt(instr_rt), .instr_rd(instr_rd),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_r0(alu_r0), .alu_overflow(alu_overflow), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .result(result), .flag_v(flag_v), .flag_z(flag_z), .flag_c(flag_c),
    .done(done), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Reference ALU: 010 add, 110 sub, 000 and, 001 or
  always_comb begin
    logic [WIDTH:0] wide;
    wide         = '0;
    alu_r0       = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op)
      3'b010: begin
        wide         = {1'b0, alu_a} + {1'b0, alu_b};
        alu_r0       = wide[WIDTH-1:0];
        alu_carry    = wide[WIDTH];
        alu_overflow = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_r0[WIDTH-1] != alu_a[WIDTH-1]);
      end
      3'b110: begin
        alu_r0       = alu_a - alu_b;
        alu_carry    = alu_a < alu_b;
        alu_overflow = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_r0[WIDTH-1] != alu_a[WIDTH-1]);
      end
      3'b000:  alu_r0 = alu_a & alu_b;
      3'b001:  alu_r0 = alu_a | alu_b;
      default: alu_r0 = '0;
    endcase
    alu_zero = (alu_r0 == '0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [REG_AW-1:0] a, input logic [WIDTH-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  task automatic peek(input logic [REG_AW-1:0] a, output logic [WIDTH-1:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  // Leaves the bench one cycle after the accept edge, i.e. in EXEC
  task automatic issue(input logic [2:0] op, input logic [REG_AW-1:0] rs,
                       input logic [REG_AW-1:0] rt, input logic [REG_AW-1:0] rd);
    instr_valid = 1'b1; instr_op = op; instr_rs = rs; instr_rt = rt; instr_rd = rd;
    step();
    instr_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (done) break;
      step();
    end
    if (k == budget) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] v;
    int               seen;

    rst_n = 1'b0; instr_valid = 1'b0; instr_op = '0;
    instr_rs = '0; instr_rt = '0; instr_rd = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    check("init_ready", instr_ready, 1);
    check("init_done", done, 0);

    load(3'd1, 32'd5);
    load(3'd2, 32'd7);
    load(3'd0, 32'd33);
    peek(3'd0, v); check("ld_r0_ignored", v, 0);

    // Basic add
    issue(3'b010, 3'd1, 3'd2, 3'd3);
    check("c1_alu_a", alu_a, 5);
    check("c1_alu_b", alu_b, 7);
    check("c1_alu_op", alu_op, 3'b010);
    check("c1_ready", instr_ready, 0);
    check("c1_done", done, 0);
    step();
    check("c2_done", done, 1);
    check("c2_result", result, 12);
    check("c2_flag_z", flag_z, 0);
    step();
    check("c3_done", done, 0);
    check("c3_ready", instr_ready, 1);
    peek(3'd3, v); check("c3_r3", v, 12);

    // Destination r0
    issue(3'b010, 3'd1, 3'd2, 3'd0);
    wait_done("r0", 5);
    check("r0_done", done, 1);
    check("r0_result", result, 12);
    step();
    peek(3'd0, v); check("r0_reads_zero", v, 0);

    // Back-to-back dependency with instr_valid held high
    load(3'd3, 32'd0);
    instr_valid = 1'b1; instr_op = 3'b010; instr_rs = 3'd1; instr_rt = 3'd2; instr_rd = 3'd3;
    step();
    instr_rs = 3'd3; instr_rt = 3'd1; instr_rd = 3'd4;
    check("b2b_exec_ready", instr_ready, 0);
    step();
    check("b2b_wb_ready", instr_ready, 0);
    check("b2b_wb_result", result, 12);
    step();
    check("b2b_idle_ready", instr_ready, 1);
    step();
    instr_valid = 1'b0;
    check("b2b_second_accepted", instr_ready, 0);
    check("b2b_alu_a", alu_a, 12);
    check("b2b_alu_b", alu_b, 5);
    wait_done("b2b", 5);
    check("b2b_result", result, 17);
    step();
    peek(3'd4, v); check("b2b_r4", v, 17);

    // Load during EXEC is dropped
    issue(3'b000, 3'd1, 3'd2, 3'd0);
    ld_en = 1'b1; ld_addr = 3'd1; ld_data = 32'd99;
    step();
    ld_en = 1'b0;
    check("and_result", result, 5);
    step();
    peek(3'd1, v); check("ld_exec_dropped", v, 5);

    // Load and accept on the same edge
    instr_valid = 1'b1; instr_op = 3'b010; instr_rs = 3'd1; instr_rt = 3'd2; instr_rd = 3'd0;
    ld_en = 1'b1; ld_addr = 3'd1; ld_data = 32'd9;
    step();
    instr_valid = 1'b0; ld_en = 1'b0;
    check("same_edge_alu_a", alu_a, 5);
    peek(3'd1, v); check("same_edge_r1", v, 9);
    wait_done("same_edge", 5);
    check("same_edge_result", result, 12);
    step();

    // Carry out to zero
    load(3'd6, 32'hFFFF_FFF7);
    issue(3'b010, 3'd6, 3'd1, 3'd6);
    step();
    check("carry_result", result, 0);
    check("carry_flag_c", flag_c, 1);
    check("carry_flag_z", flag_z, 1);
    check("carry_flag_v", flag_v, 0);
    step();
    peek(3'd6, v); check("carry_r6", v, 0);

    // Reset during EXEC
    issue(3'b010, 3'd1, 3'd2, 3'd5);
    check("rst_pre_alu_a", alu_a, 9);
    rst_n = 1'b0;
    #1;
    check("rst_ready_low", instr_ready, 0);
    check("rst_done", done, 0);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done) seen++;
    end
    check("rst_no_done", seen, 0);
    check("rst_ready", instr_ready, 1);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_result", result, 0);
    check("rst_flags", {flag_v, flag_z, flag_c}, 0);
    for (int a = 0; a < (1 << REG_AW); a++) begin
      peek(a[REG_AW-1:0], v);
      check($sformatf("rst_reg%0d", a), v, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Operand-issue and writeback stage wrapped around the combinational ALU. It accepts one instruction per valid/ready handshake and reads two source operands from an internal register file. It presents them, with the opcode, to the ALU's R2/R3/ALUOp inputs for one stable cycle, then captures R0 and the overflow/zero/carry flags and writes the result back to the destination register. It is the register-file side of the datapath: it drives the ALU and consumes its result.

## Interface
- WIDTH, 32, datapath width; must match the ALU's WIDTH.
- REG_AW, 3, register address width; the register file holds 2**REG_AW entries.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- instr_valid  in  1  an instruction is offered.
- instr_ready  out  1  the stage can accept; equals (state==IDLE) && rst_n.
- instr_op  in  3  opcode passed to the ALU unmodified.
- instr_rs, instr_rt, instr_rd  in  REG_AW each  source A, source B and destination register.
- ld_en  in  1  external register load strobe.
- ld_addr  in  REG_AW  external load address.
- ld_data  in  WIDTH  external load data.
- alu_a  out  WIDTH  drives ALU R2.
- alu_b  out  WIDTH  drives ALU R3.
- alu_op  out  3  drives ALU ALUOp.
- alu_r0  in  WIDTH  ALU result.
- alu_overflow, alu_zero, alu_carry  in  1 each  ALU flags.
- result  out  WIDTH  registered result of the last executed instruction.
- flag_v, flag_z, flag_c  out  1 each  registered flags of the last executed instruction.
- done  out  1  one-cycle pulse during WB.
- dbg_addr  in  REG_AW  debug read address.
- dbg_data  out  WIDTH  combinational read of reg[dbg_addr].

## Operation
- FSM states: IDLE, EXEC, WB.
  - IDLE -> EXEC on instr_valid && instr_ready.
  - EXEC -> WB unconditionally.
  - WB -> IDLE unconditionally.
- Accept edge:
  - alu_a <= reg[rs] and alu_b <= reg[rt], using register contents before any same-edge write.
  - alu_op <= instr_op; a rd latch <= instr_rd.
- End of EXEC: result <= alu_r0, flag_v <= alu_overflow, flag_z <= alu_zero, flag_c <= alu_carry.
- WB:
  - done = 1.
  - At the end of WB, reg[rd] <= result, unless rd == 0.
- Register 0:
  - Always reads 0.
  - Writes to it are ignored from both WB and the load port.
  - done and the flags still update when rd == 0.
- Load port:
  - The load takes effect only at an edge where state==IDLE; ld_en in EXEC or WB is dropped.
  - A load and an accept at the same edge both take effect. The operands see the pre-load value.
- alu_a, alu_b and alu_op hold their values from the accept edge until the next accept, so the ALU inputs stay stable through EXEC.
- Flags and result hold until the next EXEC completes.
- Reset (asynchronous, at any time, including mid-instruction):
  - state=IDLE; every register file entry = 0.
  - alu_a, alu_b, alu_op, result, flags and done = 0.
  - The in-flight instruction is abandoned with no writeback.

## Timing
- Cycle 0 (IDLE): handshake; operands are latched at its closing edge.
- Cycle 1 (EXEC): ALU inputs are valid; the ALU settles combinationally within the cycle; result and flags are captured at the closing edge.
- Cycle 2 (WB): done=1 and result/flags are visible; the register file write occurs at the closing edge.
- Cycle 3 (IDLE): the written value is visible on dbg_data, instr_ready=1, and the next accept is possible.
- Throughput: one instruction per 3 cycles.
- No data hazard: a dependent instruction accepted in cycle 3 reads the updated register.
- instr_ready=0 throughout EXEC and WB; instr_valid is ignored there.

## Test plan
- Reset: assert rst_n=0 mid-run, then release -> dbg_data=0 for every address, instr_ready=1, done=0, and flags, alu_a, alu_b and alu_op all 0.
- Basic op (bench ALU model: op 3'b010 = add):
  - Stimulus: load r1=5 and r2=7, then issue op=3'b010, rs=1, rt=2, rd=3.
  - Cycle 1: alu_a=5, alu_b=7, alu_op=3'b010.
  - Cycle 2: done=1, result=12, flag_z=0.
  - Cycle 3: dbg_data(r3)=12.
- Destination r0: issue r1+r2 with rd=0 using the bench ALU add -> done pulses, result=12, and r0 still reads 0.
- Back-to-back dependency:
  - Stimulus: hold instr_valid=1 for two instructions, r3=r1+r2 then r4=r3+r1.
  - Required: the second is accepted exactly 3 cycles after the first, alu_a=12 for it, and r4=17.
- Reset during EXEC: pull rst_n low in cycle 1 of an instruction with rd=5 -> r5 stays 0, state=IDLE, done is never asserted.
- Load interaction:
  - ld_en with ld_addr=1 and ld_data=99 during EXEC -> r1 unchanged.
  - ld_en with ld_addr=1 and ld_data=9 at the same edge as accepting rs=1 (r1=5) -> alu_a=5, and r1=9 afterward.
